tdm_scan_capture: RTL and testbench

TDM_SCAN_CAPTURE -- requirements
Module: tdm_scan_capture

---
 rtl/tdm_scan_capture.sv | 99 +++++++++
 tb/tb_tdm_scan_capture.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_scan_capture.sv
// Scans the eight channels of an external 8:1 multiplexer, samples each one after a settle
// window, and publishes the complete frame atomically on the data output.
module tdm_scan_capture #(
  parameter int unsigned SETTLE = 1,
  parameter bit          DIR    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mux_out,
  output logic [2:0] sel,
  output logic       busy,
  output logic       done,
  output logic [7:0] data
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE);

  state_t     state_q, state_d;
  logic [2:0] chan_q, chan_d;
  logic [3:0] settle_q, settle_d;
  logic [7:0] shadow_q, shadow_d;
  logic [7:0] data_q, data_d;
  logic       done_q, done_d;
  logic [7:0] captured;

  // chan_q counts scanned channels; in descending order the select is its complement.
  assign sel  = DIR ? ~chan_q : chan_q;
  assign busy = (state_q == SCAN);
  assign done = done_q;
  assign data = data_q;

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    settle_d = settle_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    done_d   = 1'b0;

    captured      = shadow_q;
    captured[sel] = mux_out;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SCAN;
          chan_d   = 3'd0;
          settle_d = SETTLE_RELOAD;
        end
      end
      SCAN: begin
        if (settle_q == 4'd0) begin
          shadow_d = captured;
          if (chan_q == 3'd7) begin
            // Last channel: the frame including this sample is published in one update.
            data_d   = captured;
            done_d   = 1'b1;
            state_d  = IDLE;
            chan_d   = 3'd0;
            settle_d = 4'd0;
          end else begin
            chan_d   = chan_q + 3'd1;
            settle_d = SETTLE_RELOAD;
          end
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  // NOTE: the shadow frame is reset as well, so an aborted scan never leaks partial data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      chan_q   <= 3'd0;
      settle_q <= 4'd0;
      shadow_q <= 8'h00;
      data_q   <= 8'h00;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      chan_q   <= chan_d;
      settle_q <= settle_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_tdm_scan_capture.sv
// Self-checking bench for tdm_scan_capture: three instances with different SETTLE/DIR,
// each driven by a modelled 8:1 mux, compared against a sample-time reference model.
module tb_tdm_scan_capture;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start_v [3];
  logic [7:0] pat_v   [3];
  logic [7:0] last_data [3];

  logic [2:0] sel0, sel1, sel2;
  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;
  logic [7:0] data0, data1, data2;
  logic       mux0, mux1, mux2;

  assign mux0 = pat_v[0][sel0];
  assign mux1 = pat_v[1][sel1];
  assign mux2 = pat_v[2][sel2];

  tdm_scan_capture #(.SETTLE(1), .DIR(1'b0)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .mux_out(mux0),
    .sel(sel0), .busy(busy0), .done(done0), .data(data0));
  tdm_scan_capture #(.SETTLE(0), .DIR(1'b1)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .mux_out(mux1),
    .sel(sel1), .busy(busy1), .done(done1), .data(data1));
  tdm_scan_capture #(.SETTLE(2), .DIR(1'b1)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .mux_out(mux2),
    .sel(sel2), .busy(busy2), .done(done2), .data(data2));

  int checks = 0;
  int errors = 0;

  function automatic int settle_of(int i);
    case (i)
      0: return 1;
      1: return 0;
      default: return 2;
    endcase
  endfunction

  function automatic bit dir_of(int i);
    return (i != 0);
  endfunction

  function automatic logic [2:0] sel_of(int i);
    case (i)
      0: return sel0;
      1: return sel1;
      default: return sel2;
    endcase
  endfunction

  function automatic logic busy_of(int i);
    case (i)
      0: return busy0;
      1: return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic logic done_of(int i);
    case (i)
      0: return done0;
      1: return done1;
      default: return done2;
    endcase
  endfunction

  function automatic logic [7:0] data_of(int i);
    case (i)
      0: return data0;
      1: return data1;
      default: return data2;
    endcase
  endfunction

  // Channel visited in the k-th window of a scan.
  function automatic int chan_at(int i, int k);
    return dir_of(i) ? 7 - k : k;
  endfunction

  // Expected frame: channel of window k is sampled at edge (k+1)*(SETTLE+1) after E0;
  // the mux pattern switches from p0 to p1 for edges strictly after chg.
  function automatic logic [7:0] model_frame(int i, logic [7:0] p0, logic [7:0] p1, int chg);
    logic [7:0] f;
    logic [7:0] src;
    int edge_n;
    f = 8'h00;
    for (int k = 0; k < 8; k++) begin
      edge_n = (k + 1) * (settle_of(i) + 1);
      src = (edge_n > chg) ? p1 : p0;
      f[chan_at(i, k)] = src[chan_at(i, k)];
    end
    return f;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(int i, logic [7:0] exp_data, string tag);
    check({tag, " busy"}, 32'(busy_of(i)), 32'd0);
    check({tag, " done"}, 32'(done_of(i)), 32'd0);
    check({tag, " data"}, 32'(data_of(i)), 32'(exp_data));
    check({tag, " sel"},  32'(sel_of(i)),  32'(chan_at(i, 0)));
  endtask

  // One scan on instance i; extra_start>0 pulses start so it is sampled at edge E0+extra_start.
  task automatic run_scan(int i, logic [7:0] p0, logic [7:0] p1, int chg, int extra_start);
    int s;
    int len;
    logic [7:0] frame;
    s     = settle_of(i);
    len   = 8 * (s + 1);
    frame = model_frame(i, p0, p1, chg);
    pat_v[i]   = p0;
    start_v[i] = 1'b1;
    tick();
    start_v[i] = 1'b0;
    for (int m = 0; m < len; m++) begin
      if (m == chg) pat_v[i] = p1;
      check("scan sel",  32'(sel_of(i)),  32'(chan_at(i, m / (s + 1))));
      check("scan busy", 32'(busy_of(i)), 32'd1);
      check("scan done", 32'(done_of(i)), 32'd0);
      check("scan data hold", 32'(data_of(i)), 32'(last_data[i]));
      start_v[i] = (m + 1 == extra_start);
      tick();
    end
    start_v[i] = 1'b0;
    check("end done",  32'(done_of(i)), 32'd1);
    check("end busy",  32'(busy_of(i)), 32'd0);
    check("end data",  32'(data_of(i)), 32'(frame));
    check("end sel",   32'(sel_of(i)),  32'(chan_at(i, 0)));
    last_data[i] = frame;
    tick();
    check_idle(i, frame, "post");
  endtask

  initial begin
    int n_done;
    int t_done [3];
    logic [7:0] d_done [3];
    logic [7:0] p0, p1;
    int len;

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_v[i]   = 1'b0;
      pat_v[i]     = 8'h00;
      last_data[i] = 8'h00;
    end
    #2;
    for (int i = 0; i < 3; i++) check_idle(i, 8'h00, "reset");
    tick();
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) check_idle(i, 8'h00, "after reset");

    // Constant pattern, ascending, SETTLE=1.
    run_scan(0, 8'hF8, 8'hF8, 1000, 0);
    check("const F8", 32'(data0), 32'hF8);

    // Descending, SETTLE=0.
    run_scan(1, 8'hA5, 8'hA5, 1000, 0);
    check("desc A5", 32'(data1), 32'hA5);

    // Start while busy is ignored.
    run_scan(0, 8'h3C, 8'h3C, 1000, 5);
    check("ignored start 3C", 32'(data0), 32'h3C);

    // Input change right after the channel-3 sample (edge E0+8).
    run_scan(0, 8'hFF, 8'h00, 8, 0);
    check("midscan change 0F", 32'(data0), 32'h0F);

    // Continuous start: back-to-back scans with one idle cycle each.
    pat_v[0]   = 8'h0F;
    start_v[0] = 1'b1;
    n_done     = 0;
    for (int c = 0; c < 80 && n_done < 3; c++) begin
      tick();
      if (done0 === 1'b1) begin
        t_done[n_done] = c;
        d_done[n_done] = data0;
        n_done++;
        if (n_done == 1) pat_v[0] = 8'hF0;
      end
    end
    start_v[0] = 1'b0;
    check("cont done count", 32'(n_done), 32'd3);
    if (n_done == 3) begin
      check("cont gap1", 32'(t_done[1] - t_done[0]), 32'd17);
      check("cont gap2", 32'(t_done[2] - t_done[1]), 32'd17);
      check("cont data1", 32'(d_done[0]), 32'h0F);
      check("cont data2", 32'(d_done[1]), 32'hF0);
      check("cont data3", 32'(d_done[2]), 32'hF0);
    end
    for (int c = 0; c < 40 && busy0 === 1'b1; c++) tick();
    tick();
    last_data[0] = 8'hF0;
    check_idle(0, 8'hF0, "cont drained");

    // Reset between edges mid-scan: outputs clear immediately, no done, data zero.
    pat_v[0]   = 8'h55;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    for (int c = 0; c < 7; c++) tick();
    check("pre-reset busy", 32'(busy0), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      last_data[i] = 8'h00;
      check_idle(i, 8'h00, "async reset");
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      check("no done after abort", 32'(done0), 32'd0);
    end
    check_idle(0, 8'h00, "after abort");
    run_scan(0, 8'h96, 8'h96, 1000, 0);

    // Randomized scans on every instance with a random mid-scan change and ignored start.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 3; i++) begin
        len = 8 * (settle_of(i) + 1);
        p0  = 8'($urandom);
        p1  = 8'($urandom);
        run_scan(i, p0, p1, int'($urandom_range(0, len + 1)), int'($urandom_range(0, len)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
